// File: rtl/sr_weight_feeder.sv
// Weight feeder for a stride-KS convolution stage.
// Streams raster-order pixels (channel fastest) and pairs each accepted pixel
// with its kernel weight from a local memory loaded while idle. A single bias
// register is driven continuously. A missing pixel mid-frame is flagged as a
// sticky underflow and emits a zero pixel/weight pair.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   S_IDLE | waiting for start; weight and bias writes accepted here only
//   S_RUN  | accepting pixels, advancing ch/kc/pc/kr/band counters
//   S_DONE | one-cycle gap after the last accept, last pair on the outputs

module sr_weight_feeder #(
  parameter int CH = 64,
  parameter int KS = 8,
  parameter int PW = 22,
  parameter int PH = 22,
  parameter int AW = $clog2(CH * KS * KS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cfg_we,
  input  logic [AW-1:0] cfg_addr,
  input  logic [15:0]   cfg_wdata,
  input  logic          cfg_bias_we,
  input  logic          start,
  input  logic          pix_valid,
  input  logic [15:0]   pix_data,
  output logic [15:0]   in_data,
  output logic          in_valid,
  output logic [15:0]   weight,
  output logic [15:0]   bias,
  output logic          busy,
  output logic          done,
  output logic          err_underflow
);

  localparam int DEPTH = CH * KS * KS;
  localparam int CHW   = (CH > 1) ? $clog2(CH) : 1;
  localparam int KSW   = (KS > 1) ? $clog2(KS) : 1;
  localparam int PWW   = (PW > 1) ? $clog2(PW) : 1;
  localparam int PHW   = (PH > 1) ? $clog2(PH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state;
  logic [CHW-1:0]  ch;
  logic [KSW-1:0]  kc;
  logic [PWW-1:0]  pc;
  logic [KSW-1:0]  kr;
  logic [PHW-1:0]  band;
  logic            started;

  logic [15:0]     mem [DEPTH];

  logic            accept;
  logic            gap;
  logic            idle_start;
  logic            ch_last;
  logic            kc_last;
  logic            pc_last;
  logic            kr_last;
  logic            band_last;
  logic            frame_last;
  logic [AW-1:0]   rd_addr;

  assign accept     = (state == S_RUN) && pix_valid;
  // A gap only counts once the frame has started flowing.
  assign gap        = (state == S_RUN) && !pix_valid && started;
  assign idle_start = (state == S_IDLE) && start;

  assign ch_last    = (ch   == CHW'(CH - 1));
  assign kc_last    = (kc   == KSW'(KS - 1));
  assign pc_last    = (pc   == PWW'(PW - 1));
  assign kr_last    = (kr   == KSW'(KS - 1));
  assign band_last  = (band == PHW'(PH - 1));
  assign frame_last = ch_last && kc_last && pc_last && kr_last && band_last;

  // The patch column does not enter the address: every patch reuses the kernel.
  assign rd_addr = AW'(int'(kr) * KS * CH + int'(kc) * CH + int'(ch));

  // Weight memory write port; bias write in the same cycle wins.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && cfg_we && !cfg_bias_we) begin
      mem[cfg_addr] <= cfg_wdata;
    end
  end

  // Bias register; cleared by reset, so software must rewrite it afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bias <= '0;
    end else if (state == S_IDLE && cfg_bias_we) begin
      bias <= cfg_wdata;
    end
  end

  // Registered pixel/weight pair; zeros whenever nothing was accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_data <= '0;
      weight  <= '0;
    end else begin
      in_data <= accept ? pix_data : '0;
      weight  <= accept ? mem[rd_addr] : '0;
    end
  end

  // Control FSM, position counters and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      ch            <= '0;
      kc            <= '0;
      pc            <= '0;
      kr            <= '0;
      band          <= '0;
      started       <= 1'b0;
      in_valid      <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      in_valid <= accept && !started;
      done     <= (state == S_DONE);

      if (idle_start) begin
        err_underflow <= 1'b0;
      end else if (gap) begin
        err_underflow <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          busy <= start;
          if (start) begin
            state   <= S_RUN;
            started <= 1'b0;
            ch      <= '0;
            kc      <= '0;
            pc      <= '0;
            kr      <= '0;
            band    <= '0;
          end
        end
        S_RUN: begin
          busy <= !(accept && frame_last);
          if (accept) begin
            started <= 1'b1;
            if (frame_last) begin
              state <= S_DONE;
            end
            if (ch_last) begin
              ch <= '0;
              if (kc_last) begin
                kc <= '0;
                if (pc_last) begin
                  pc <= '0;
                  if (kr_last) begin
                    kr <= '0;
                    if (band_last) begin
                      band <= '0;
                    end else begin
                      band <= band + 1'b1;
                    end
                  end else begin
                    kr <= kr + 1'b1;
                  end
                end else begin
                  pc <= pc + 1'b1;
                end
              end else begin
                kc <= kc + 1'b1;
              end
            end else begin
              ch <= ch + 1'b1;
            end
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sr_weight_feeder.sv
// Self-checking bench for sr_weight_feeder using a reduced geometry so that
// whole frames fit in a short run. Expected outputs come from a reference
// that derives the kernel address from the linear pixel index.

module tb_sr_weight_feeder;

  localparam int CH    = 4;
  localparam int KS    = 2;
  localparam int PW    = 3;
  localparam int PH    = 2;
  localparam int AW    = 4;
  localparam int DEPTH = CH * KS * KS;
  localparam int FRAME = PH * KS * PW * KS * CH;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cfg_we;
  logic [AW-1:0] cfg_addr;
  logic [15:0]   cfg_wdata;
  logic          cfg_bias_we;
  logic          start;
  logic          pix_valid;
  logic [15:0]   pix_data;
  logic [15:0]   in_data;
  logic          in_valid;
  logic [15:0]   weight;
  logic [15:0]   bias;
  logic          busy;
  logic          done;
  logic          err_underflow;

  sr_weight_feeder #(.CH(CH), .KS(KS), .PW(PW), .PH(PH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cfg_we        (cfg_we),
    .cfg_addr      (cfg_addr),
    .cfg_wdata     (cfg_wdata),
    .cfg_bias_we   (cfg_bias_we),
    .start         (start),
    .pix_valid     (pix_valid),
    .pix_data      (pix_data),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .weight        (weight),
    .bias          (bias),
    .busy          (busy),
    .done          (done),
    .err_underflow (err_underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    logic [15:0] w;
    logic        v;
    logic        err;
    logic        dn;
    logic        bz;
  } exp_t;

  typedef struct {
    logic        pv;
    logic [15:0] pd;
    logic [15:0] ed;
    logic [15:0] ew;
    logic        ev;
    logic        eerr;
  } vec_t;

  int          total = 0;
  int          bad   = 0;
  exp_t        sb[$];
  vec_t        tbl[13];
  logic [15:0] wmem[DEPTH];
  logic [15:0] m_bias;
  int          m_idx;
  bit          m_started;
  bit          m_err;

  function automatic int addr_of(input int n);
    int c, kc, kr;
    c  = n % CH;
    kc = (n / CH) % KS;
    kr = (n / (CH * KS * PW)) % KS;
    return kr * KS * CH + kc * CH + c;
  endfunction

  function automatic exp_t mk(input logic [15:0] d, input logic [15:0] w, input logic v,
                              input logic err, input logic dn, input logic bz);
    exp_t e;
    e.d = d; e.w = w; e.v = v; e.err = err; e.dn = dn; e.bz = bz;
    return e;
  endfunction

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: scoreboard empty got in_data %h want an entry", tag, in_data);
      return;
    end
    e = sb.pop_front();
    chk16({tag, ".in_data"}, in_data, e.d);
    chk16({tag, ".weight"},  weight,  e.w);
    chk1 ({tag, ".in_valid"}, in_valid, e.v);
    chk1 ({tag, ".err"},  err_underflow, e.err);
    chk1 ({tag, ".done"}, done, e.dn);
    chk1 ({tag, ".busy"}, busy, e.bz);
    chk16({tag, ".bias"}, bias, m_bias);
  endtask

  task automatic px(input logic pv, input logic [15:0] pd, input string tag);
    exp_t e;
    pix_valid = pv;
    pix_data  = pd;
    if (pv) begin
      int a;
      a = addr_of(m_idx);
      e = mk(pd, wmem[a], !m_started, m_err, 1'b0, 1'b1);
      m_started = 1'b1;
      m_idx++;
      e.bz = (m_idx != FRAME);
    end else begin
      if (m_started) m_err = 1'b1;
      e = mk(16'h0, 16'h0, 1'b0, m_err, 1'b0, 1'b1);
    end
    sb.push_back(e);
    tick();
    check_out(tag);
  endtask

  task automatic frame_tail(input string tag);
    pix_valid = 1'b1;
    pix_data  = 16'hBEEF;
    sb.push_back(mk(16'h0, 16'h0, 1'b0, m_err, 1'b1, 1'b0));
    tick();
    check_out({tag, ".done"});
    pix_valid = 1'b0;
    sb.push_back(mk(16'h0, 16'h0, 1'b0, m_err, 1'b0, 1'b0));
    tick();
    check_out({tag, ".after"});
  endtask

  task automatic do_start(input logic we, input logic [AW-1:0] a, input logic [15:0] wd);
    start     = 1'b1;
    cfg_we    = we;
    cfg_addr  = a;
    cfg_wdata = wd;
    pix_valid = 1'b1;
    pix_data  = 16'hDEAD;
    if (we) wmem[a] = wd;
    m_idx = 0; m_started = 1'b0; m_err = 1'b0;
    sb.push_back(mk(16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1));
    tick();
    start = 1'b0; cfg_we = 1'b0; pix_valid = 1'b0;
    check_out("start");
  endtask

  task automatic load_weights();
    for (int a = 0; a < DEPTH; a++) begin
      cfg_we    = 1'b1;
      cfg_addr  = AW'(a);
      cfg_wdata = 16'(16'hA000 + a);
      wmem[a]   = 16'(16'hA000 + a);
      tick();
    end
    cfg_we = 1'b0;
  endtask

  task automatic write_bias(input logic [15:0] d);
    cfg_bias_we = 1'b1;
    cfg_wdata   = d;
    tick();
    cfg_bias_we = 1'b0;
    m_bias      = d;
  endtask

  task automatic chk_all_zero(input string tag);
    chk16({tag, ".in_data"}, in_data, 16'h0);
    chk16({tag, ".weight"},  weight,  16'h0);
    chk16({tag, ".bias"},    bias,    16'h0);
    chk1 ({tag, ".in_valid"}, in_valid, 1'b0);
    chk1 ({tag, ".busy"}, busy, 1'b0);
    chk1 ({tag, ".done"}, done, 1'b0);
    chk1 ({tag, ".err"},  err_underflow, 1'b0);
  endtask

  initial begin
    // {pv, pd, expected in_data, expected weight, expected in_valid, expected err}
    tbl[0]  = '{1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 16'h1234, 16'h1234, 16'hA000, 1'b1, 1'b0};
    tbl[2]  = '{1'b1, 16'h0002, 16'h0002, 16'hA001, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 16'h8003, 16'h8003, 16'hA002, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 16'h5555, 16'h0000, 16'h0000, 1'b0, 1'b1};
    tbl[5]  = '{1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1};
    tbl[6]  = '{1'b1, 16'h0004, 16'h0004, 16'hA003, 1'b0, 1'b1};
    tbl[7]  = '{1'b1, 16'hFFFF, 16'hFFFF, 16'hA004, 1'b0, 1'b1};
    tbl[8]  = '{1'b1, 16'h0005, 16'h0005, 16'hA005, 1'b0, 1'b1};
    tbl[9]  = '{1'b1, 16'h0006, 16'h0006, 16'hA006, 1'b0, 1'b1};
    tbl[10] = '{1'b1, 16'h0007, 16'h0007, 16'hA007, 1'b0, 1'b1};
    tbl[11] = '{1'b1, 16'h0008, 16'h0008, 16'hA000, 1'b0, 1'b1};
    tbl[12] = '{1'b1, 16'h0009, 16'h0009, 16'hA001, 1'b0, 1'b1};

    rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0; cfg_bias_we = 1'b0;
    start = 1'b0; pix_valid = 1'b0; pix_data = '0; m_bias = '0;
    repeat (2) tick();
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick();

    load_weights();
    write_bias(16'h0100);
    chk16("bias_write", bias, 16'h0100);

    // Frame 1: hand-derived opening, then random data with random gaps.
    do_start(1'b0, '0, '0);
    for (int i = 0; i < 13; i++) begin
      pix_valid = tbl[i].pv;
      pix_data  = tbl[i].pd;
      sb.push_back(mk(tbl[i].ed, tbl[i].ew, tbl[i].ev, tbl[i].eerr, 1'b0, 1'b1));
      tick();
      check_out($sformatf("tbl%0d", i));
    end
    m_idx = 10; m_started = 1'b1; m_err = 1'b1;
    for (int n = 10; n < FRAME; n++) begin
      if ($urandom_range(0, 5) == 0) px(1'b0, 16'h0, "f1gap");
      if (n == 20) begin
        cfg_we = 1'b1; cfg_bias_we = 1'b1; cfg_addr = 4'd5; cfg_wdata = 16'h7FFF;
      end
      px(1'b1, 16'($urandom), $sformatf("f1px%0d", n));
      cfg_we = 1'b0; cfg_bias_we = 1'b0;
    end
    frame_tail("f1end");

    // Idle: bias write beats weight write in the same cycle; underflow is sticky.
    cfg_we = 1'b1; cfg_bias_we = 1'b1; cfg_addr = 4'd3; cfg_wdata = 16'h0BAD;
    tick();
    cfg_we = 1'b0; cfg_bias_we = 1'b0;
    m_bias = 16'h0BAD;
    chk16("bias_priority", bias, 16'h0BAD);
    chk1("err_sticky", err_underflow, 1'b1);

    // Frame 2: start with a same-cycle weight write, abort by reset midway.
    do_start(1'b1, 4'd6, 16'h6666);
    for (int n = 0; n < 50; n++) px(1'b1, 16'($urandom), $sformatf("f2px%0d", n));
    rst_n = 1'b0;
    pix_valid = 1'b0;
    #1;
    m_bias = '0;
    chk_all_zero("abort");
    tick();
    chk1("abort_edge.busy", busy, 1'b0);
    chk1("abort_edge.done", done, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk1($sformatf("post_abort%0d.done", i), done, 1'b0);
      chk1($sformatf("post_abort%0d.busy", i), busy, 1'b0);
    end

    // Frame 3: full contiguous frame from fresh counters.
    load_weights();
    write_bias(16'h0100);
    do_start(1'b0, '0, '0);
    for (int n = 0; n < FRAME; n++) px(1'b1, 16'($urandom), $sformatf("f3px%0d", n));
    frame_tail("f3end");
    chk1("f3_err", err_underflow, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
